// File: rtl/viterbi_ber_checker.sv
// Receive-side BER monitor: searches for the decoder latency against a history of
// source bits, then counts decoded bits and residual errors while aligned.
module viterbi_ber_checker #(
    parameter int MAX_LAT     = 64,
    parameter int SYNC_LEN    = 32,
    parameter int WIN         = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 16,
    localparam int LAT_W      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid_i,
    input  logic             tx_bit_i,
    input  logic             rx_valid_i,
    input  logic             rx_bit_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic [LAT_W-1:0] latency_o,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             cnt_sat_o,
    output logic             lock_lost_o,
    output logic             dbg_state_o
);

    localparam int FILL_W = $clog2(MAX_LAT + 1);
    localparam int RUN_W  = $clog2(SYNC_LEN + 1);
    localparam int WCNT_W = $clog2(WIN + 1);
    localparam int WERR_W = $clog2(LOSS_THRESH + 1);

    typedef enum logic {
        S_SEARCH = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             r_state, w_state_n;
    logic [MAX_LAT-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [LAT_W-1:0]   r_cand, w_cand_n;
    logic [RUN_W-1:0]   r_run, w_run_n;
    logic               r_locked, w_locked_n;
    logic [LAT_W-1:0]   r_lat, w_lat_n;
    logic [CNT_W-1:0]   r_bit, w_bit_n;
    logic [CNT_W-1:0]   r_err, w_err_n;
    logic               r_sat, w_sat_n;
    logic               r_lost, w_lost_n;
    logic [WCNT_W-1:0]  r_wcnt, w_wcnt_n;
    logic [WERR_W-1:0]  r_werr, w_werr_n;

    logic w_legal;
    logic w_match_cand;
    logic w_match_lat;

    // Comparisons look at the history as it was before this cycle's tx shift.
    assign w_legal      = (r_fill > FILL_W'(r_cand));
    assign w_match_cand = (rx_bit_i == r_hist[r_cand]);
    assign w_match_lat  = (rx_bit_i == r_hist[r_lat]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (tx_valid_i) begin
            r_hist <= {r_hist[MAX_LAT-2:0], tx_bit_i};
            if (r_fill != FILL_W'(MAX_LAT))
                r_fill <= r_fill + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_SEARCH;
            r_cand   <= '0;
            r_run    <= '0;
            r_locked <= 1'b0;
            r_lat    <= '0;
            r_bit    <= '0;
            r_err    <= '0;
            r_sat    <= 1'b0;
            r_lost   <= 1'b0;
            r_wcnt   <= '0;
            r_werr   <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cand   <= w_cand_n;
            r_run    <= w_run_n;
            r_locked <= w_locked_n;
            r_lat    <= w_lat_n;
            r_bit    <= w_bit_n;
            r_err    <= w_err_n;
            r_sat    <= w_sat_n;
            r_lost   <= w_lost_n;
            r_wcnt   <= w_wcnt_n;
            r_werr   <= w_werr_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_cand_n   = r_cand;
        w_run_n    = r_run;
        w_locked_n = r_locked;
        w_lat_n    = r_lat;
        w_bit_n    = r_bit;
        w_err_n    = r_err;
        w_sat_n    = r_sat;
        w_lost_n   = 1'b0;
        w_wcnt_n   = r_wcnt;
        w_werr_n   = r_werr;

        if (clear_i) begin
            w_state_n  = S_SEARCH;
            w_cand_n   = '0;
            w_run_n    = '0;
            w_locked_n = 1'b0;
            w_lat_n    = '0;
            w_bit_n    = '0;
            w_err_n    = '0;
            w_sat_n    = 1'b0;
            w_wcnt_n   = '0;
            w_werr_n   = '0;
        end else if (rx_valid_i) begin
            case (r_state)
                S_SEARCH: begin
                    if (w_legal) begin
                        if (w_match_cand) begin
                            if (r_run == RUN_W'(SYNC_LEN - 1)) begin
                                w_state_n  = S_LOCKED;
                                w_locked_n = 1'b1;
                                w_lat_n    = r_cand;
                                w_run_n    = '0;
                                w_wcnt_n   = '0;
                                w_werr_n   = '0;
                            end else begin
                                w_run_n = r_run + 1'b1;
                            end
                        end else begin
                            w_run_n  = '0;
                            w_cand_n = (r_cand == LAT_W'(MAX_LAT - 1)) ? '0 : r_cand + 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    if (r_bit != {CNT_W{1'b1}}) begin
                        w_bit_n = r_bit + 1'b1;
                        if (w_bit_n == {CNT_W{1'b1}})
                            w_sat_n = 1'b1;
                    end
                    if (!w_match_lat) begin
                        w_werr_n = r_werr + 1'b1;
                        if (r_err != {CNT_W{1'b1}}) begin
                            w_err_n = r_err + 1'b1;
                            if (w_err_n == {CNT_W{1'b1}})
                                w_sat_n = 1'b1;
                        end
                    end
                    // Loss of lock takes precedence over the window rollover.
                    if (w_werr_n == WERR_W'(LOSS_THRESH)) begin
                        w_state_n  = S_SEARCH;
                        w_locked_n = 1'b0;
                        w_lost_n   = 1'b1;
                        w_cand_n   = (r_lat == LAT_W'(MAX_LAT - 1)) ? '0 : r_lat + 1'b1;
                        w_run_n    = '0;
                        w_wcnt_n   = '0;
                        w_werr_n   = '0;
                    end else if (r_wcnt == WCNT_W'(WIN - 1)) begin
                        w_wcnt_n = '0;
                        w_werr_n = '0;
                    end else begin
                        w_wcnt_n = r_wcnt + 1'b1;
                    end
                end
                default: w_state_n = S_SEARCH;
            endcase
        end
    end

    assign locked_o    = r_locked;
    assign latency_o   = r_lat;
    assign bit_cnt_o   = r_bit;
    assign err_cnt_o   = r_err;
    assign cnt_sat_o   = r_sat;
    assign lock_lost_o = r_lost;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench for viterbi_ber_checker: PRBS-15 source, rx built from a delayed
// copy of tx, a scenario table plus hand sequences for lock loss, saturation and reset.
module tb_viterbi_ber_checker;

    logic clk;
    logic rst;
    logic tx_valid_i, tx_bit_i, rx_valid_i, rx_bit_i, clear_i;

    logic        locked_a, lost_a, sat_a, dbg_a;
    logic [5:0]  lat_a;
    logic [15:0] bit_a, err_a;

    logic        locked_b, lost_b, sat_b, dbg_b;
    logic [5:0]  lat_b;
    logic [7:0]  bit_b, err_b;

    viterbi_ber_checker #(.MAX_LAT(64), .SYNC_LEN(32), .WIN(64), .LOSS_THRESH(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .tx_valid_i(tx_valid_i), .tx_bit_i(tx_bit_i),
        .rx_valid_i(rx_valid_i), .rx_bit_i(rx_bit_i), .clear_i(clear_i),
        .locked_o(locked_a), .latency_o(lat_a), .bit_cnt_o(bit_a), .err_cnt_o(err_a),
        .cnt_sat_o(sat_a), .lock_lost_o(lost_a), .dbg_state_o(dbg_a)
    );

    viterbi_ber_checker #(.MAX_LAT(64), .SYNC_LEN(32), .WIN(64), .LOSS_THRESH(8), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .tx_valid_i(tx_valid_i), .tx_bit_i(tx_bit_i),
        .rx_valid_i(rx_valid_i), .rx_bit_i(rx_bit_i), .clear_i(clear_i),
        .locked_o(locked_b), .latency_o(lat_b), .bit_cnt_o(bit_b), .err_cnt_o(err_b),
        .cnt_sat_o(sat_b), .lock_lost_o(lost_b), .dbg_state_o(dbg_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   lost_cnt = 0;
    int   cur_delay = 0;
    logic [14:0] lfsr = 15'h1;
    logic sent_q[$];

    always @(negedge clk) if (lost_a) lost_cnt++;

    typedef struct {
        int delay;
        int n_bits;
        int flip_every;
        int exp_locked;
        int exp_lat;
        int exp_bits;
        int exp_errs;
    } row_t;

    row_t rows[6];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic prbs_next();
        logic nb;
        nb   = lfsr[14] ^ lfsr[13];
        lfsr = {lfsr[13:0], nb};
        return nb;
    endfunction

    // driver: one tx bit per cycle, rx = source bit cur_delay events before the newest
    task automatic step(input logic flip, input logic clr);
        logic b, r, leg;
        b   = prbs_next();
        leg = (sent_q.size() > cur_delay);
        r   = leg ? sent_q[sent_q.size() - 1 - cur_delay] : 1'b0;
        tx_valid_i = 1'b1;
        tx_bit_i   = b;
        rx_valid_i = leg;
        rx_bit_i   = r ^ flip;
        clear_i    = clr;
        @(posedge clk);
        #1;
        sent_q.push_back(b);
        if (sent_q.size() > 200) void'(sent_q.pop_front());
        tx_valid_i = 1'b0;
        rx_valid_i = 1'b0;
        clear_i    = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
    endtask

    task automatic try_lock(input int budget);
        for (int i = 0; i < budget; i++) begin
            step(1'b0, 1'b0);
            if (locked_a) break;
        end
    endtask

    initial begin
        int lost0;
        rows[0] = '{20, 1000,   0, 1, 20, 1000,  0};
        rows[1] = '{20, 1000, 100, 1, 20, 1000, 10};
        rows[2] = '{ 5,  200,   0, 1,  5,  200,  0};
        rows[3] = '{ 0,  100,   0, 1,  0,  100,  0};
        rows[4] = '{63,  150,   0, 1, 63,  150,  0};
        rows[5] = '{70, 5000,   0, 0,  0,    0,  0};

        rst = 1'b0;
        tx_valid_i = 1'b0; tx_bit_i = 1'b0; rx_valid_i = 1'b0; rx_bit_i = 1'b0; clear_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset locked", int'(locked_a), 0);
        chk("reset latency", int'(lat_a), 0);
        chk("reset bit_cnt", int'(bit_a), 0);
        chk("reset err_cnt", int'(err_a), 0);
        chk("reset cnt_sat", int'(sat_a), 0);
        chk("reset lock_lost", int'(lost_a), 0);
        chk("reset state", int'(dbg_a), 0);
        rst = 1'b1;

        // scenario table
        for (int r = 0; r < 6; r++) begin
            pulse_clear();
            cur_delay = rows[r].delay;
            try_lock(600);
            lost0 = lost_cnt;
            for (int i = 0; i < rows[r].n_bits; i++)
                step((rows[r].flip_every != 0) && ((i + 1) % rows[r].flip_every == 0), 1'b0);
            chk($sformatf("row%0d locked", r), int'(locked_a), rows[r].exp_locked);
            chk($sformatf("row%0d latency", r), int'(lat_a), rows[r].exp_lat);
            chk($sformatf("row%0d bit_cnt", r), int'(bit_a), rows[r].exp_bits);
            chk($sformatf("row%0d err_cnt", r), int'(err_a), rows[r].exp_errs);
            chk($sformatf("row%0d lost pulses", r), lost_cnt - lost0, 0);
        end

        // 16 consecutive flips: loss after the 8th, then relock at 20
        pulse_clear();
        cur_delay = 20;
        try_lock(600);
        chk("burst pre-lock", int'(locked_a), 1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        lost0 = lost_cnt;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0);
            if (k == 6) chk("burst no pulse at 7th", int'(lost_a), 0);
            if (k == 7) begin
                chk("burst pulse at 8th", int'(lost_a), 1);
                chk("burst unlocked at 8th", int'(locked_a), 0);
            end
        end
        try_lock(1000);
        chk("burst relock", int'(locked_a), 1);
        chk("burst relock latency", int'(lat_a), 20);
        chk("burst lost pulses", lost_cnt - lost0, 1);
        chk("burst bit_cnt", int'(bit_a), 18);
        chk("burst err_cnt", int'(err_a), 8);

        // saturation on the 8-bit instance, then clear with a same-cycle rx bit
        pulse_clear();
        try_lock(600);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0);
        chk("sat b bit_cnt", int'(bit_b), 255);
        chk("sat b cnt_sat", int'(sat_b), 1);
        chk("sat b err_cnt", int'(err_b), 0);
        chk("sat a bit_cnt", int'(bit_a), 300);
        chk("sat a cnt_sat", int'(sat_a), 0);
        lost0 = lost_cnt;
        step(1'b1, 1'b1);
        chk("clr a locked", int'(locked_a), 0);
        chk("clr a bit_cnt", int'(bit_a), 0);
        chk("clr a err_cnt", int'(err_a), 0);
        chk("clr a latency", int'(lat_a), 0);
        chk("clr b bit_cnt", int'(bit_b), 0);
        chk("clr b cnt_sat", int'(sat_b), 0);
        chk("clr lock_lost", int'(lost_a), 0);
        step(1'b0, 1'b0);
        chk("clr lost pulses", lost_cnt - lost0, 0);

        // asynchronous reset mid-lock
        try_lock(600);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
        chk("rst pre locked", int'(locked_a), 1);
        chk("rst pre bit_cnt", int'(bit_a), 50);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst async locked", int'(locked_a), 0);
        chk("rst async bit_cnt", int'(bit_a), 0);
        chk("rst async latency", int'(lat_a), 0);
        chk("rst async cnt_sat", int'(sat_a), 0);
        #2;
        rst = 1'b1;
        try_lock(600);
        chk("rst relock", int'(locked_a), 1);
        chk("rst relock latency", int'(lat_a), 20);
        chk("rst relock bit_cnt", int'(bit_a), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
